// File: rtl/dec_input_key.sv
// dec_input_key: serial key detector. A KEY_WIDTH-bit key (MSB first) followed by one mode
// bit arrives on inputKey, qualified by validCmd. A matching key plus mode bit latches
// active=1 and the mode until reset. A wrong key parks in an error state until validCmd drops.
// Optional feature: define DEC_INPUT_KEY_ERR_FLAG_EN to add the registered keyErr output.
module dec_input_key #(
   parameter int unsigned            KEY_WIDTH = 4,
   parameter logic [KEY_WIDTH-1:0]   KEY_VALUE = 4'b1010
) (
   input  logic clk,
   input  logic reset,
   input  logic inputKey,
   input  logic validCmd,
   output logic active,
   output logic mode
`ifdef DEC_INPUT_KEY_ERR_FLAG_EN
   ,
   output logic keyErr
`endif
);

   localparam int unsigned CntW = $clog2(KEY_WIDTH + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(KEY_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StKey, StMode, StActive, StError} state_e;

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [KEY_WIDTH-1:0]  key_q, key_d;
   logic [KEY_WIDTH:0]    key_cat;
   logic [KEY_WIDTH-1:0]  key_shift;
   logic                  active_q, active_d;
   logic                  mode_q, mode_d;
   logic [1:0]            rst_sync_q, rst_sync_d;
   logic                  rst_int_n;

   // Deassertion synchronizer: assertion clears both flops at once, release ripples in.
   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
   end

   // Reset synchronizer flops, asynchronously cleared by the external reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync_q <= 2'b00;
      else        rst_sync_q <= rst_sync_d;
   end

   assign rst_int_n = rst_sync_q[1];

   // Key register after shifting in the current bit (new bit lands in the LSB).
   always_comb begin
      key_cat   = {key_q, inputKey};
      key_shift = key_cat[KEY_WIDTH-1:0];
   end

   // State, counter and key register.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
      end
   end

   // Next-state logic: collect key bits, compare on the last one, then take the mode bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      key_d   = key_q;
      unique case (state_q)
         StIdle: begin
            if (validCmd) begin
               key_d = key_shift;
               cnt_d = CntW'(1);
               if (KEY_WIDTH == 1) state_d = (key_shift == KEY_VALUE) ? StMode : StError;
               else                state_d = StKey;
            end
         end
         StKey: begin
            if (!validCmd) begin
               state_d = StIdle;
               cnt_d   = '0;
               key_d   = '0;
            end else begin
               key_d = key_shift;
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == LastCnt) state_d = (key_shift == KEY_VALUE) ? StMode : StError;
            end
         end
         StMode: begin
            if (validCmd) begin
               state_d = StActive;
            end else begin
               state_d = StIdle;
               cnt_d   = '0;
               key_d   = '0;
            end
         end
         StActive: begin
            state_d = StActive;
         end
         StError: begin
            if (!validCmd) begin
               state_d = StIdle;
               cnt_d   = '0;
               key_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            key_d   = '0;
         end
      endcase
   end

   // Output next-state: outputs follow the state being entered so they update on the same edge.
   always_comb begin
      active_d = 1'b0;
      mode_d   = 1'b0;
      if (state_d == StActive) begin
         active_d = 1'b1;
         mode_d   = (state_q == StMode) ? inputKey : mode_q;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         active_q <= 1'b0;
         mode_q   <= 1'b0;
      end else begin
         active_q <= active_d;
         mode_q   <= mode_d;
      end
   end

   assign active = active_q;
   assign mode   = mode_q;

`ifdef DEC_INPUT_KEY_ERR_FLAG_EN
   logic key_err_q, key_err_d;

   // Error flag mirrors residence in the error state.
   always_comb begin
      key_err_d = (state_d == StError);
   end

   // Registered error flag.
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) key_err_q <= 1'b0;
      else            key_err_q <= key_err_d;
   end

   assign keyErr = key_err_q;
`endif

endmodule

// File: tb/tb_dec_input_key.sv
// Directed testbench for dec_input_key with an expected-value queue.
module tb_dec_input_key;

   logic clk = 1'b0;
   logic reset;
   logic inputKey;
   logic validCmd;
   logic active;
   logic mode;
`ifdef DEC_INPUT_KEY_ERR_FLAG_EN
   logic keyErr;
`endif

   int checks = 0;
   int errors = 0;

   // {active, mode, keyErr}
   logic [2:0] exp_q[$];

   always #5 clk = ~clk;

   dec_input_key #(
      .KEY_WIDTH (4),
      .KEY_VALUE (4'b1010)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .inputKey (inputKey),
      .validCmd (validCmd),
      .active   (active),
      .mode     (mode)
`ifdef DEC_INPUT_KEY_ERR_FLAG_EN
      ,
      .keyErr   (keyErr)
`endif
   );

   task automatic check_now(input string tag);
      logic [2:0] e;
      e = exp_q.pop_front();
      checks++;
      assert (active === e[2]) else begin
         errors++;
         $error("FAIL %s active observed %b expected %b", tag, active, e[2]);
      end
      checks++;
      assert (mode === e[1]) else begin
         errors++;
         $error("FAIL %s mode observed %b expected %b", tag, mode, e[1]);
      end
`ifdef DEC_INPUT_KEY_ERR_FLAG_EN
      checks++;
      assert (keyErr === e[0]) else begin
         errors++;
         $error("FAIL %s keyErr observed %b expected %b", tag, keyErr, e[0]);
      end
`endif
   endtask

   // One clock: drive inputs, queue the expected outputs, sample 1 time unit after the edge.
   task automatic step(input string tag, input logic v, input logic b,
                       input logic ea, input logic em, input logic ee);
      validCmd = v;
      inputKey = b;
      exp_q.push_back({ea, em, ee});
      @(posedge clk);
      #1;
      check_now(tag);
   endtask

   // Pulse reset, check outputs during reset, then let the release synchronizer settle.
   task automatic do_reset(input string tag);
      validCmd = 1'b0;
      inputKey = 1'b0;
      #2 reset = 1'b0;
      #1;
      exp_q.push_back(3'b000);
      check_now(tag);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      reset    = 1'b1;
      validCmd = 1'b0;
      inputKey = 1'b0;

      // Correct key, mode=1; then idle clocks must not disturb it.
      do_reset("rst0");
      step("k1_b1", 1, 1, 0, 0, 0);
      step("k1_b2", 1, 0, 0, 0, 0);
      step("k1_b3", 1, 1, 0, 0, 0);
      step("k1_b4", 1, 0, 0, 0, 0);
      step("k1_mode", 1, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) step("k1_hold", 0, 0, 1, 1, 0);

      // Correct key, mode=0.
      do_reset("rst1");
      step("k2_b1", 1, 1, 0, 0, 0);
      step("k2_b2", 1, 0, 0, 0, 0);
      step("k2_b3", 1, 1, 0, 0, 0);
      step("k2_b4", 1, 0, 0, 0, 0);
      step("k2_mode", 1, 0, 1, 0, 0);
      step("k2_hold", 0, 1, 1, 0, 0);

      // Wrong key -> error, held while valid, cleared when valid drops, then a good key.
      do_reset("rst2");
      step("e_b1", 1, 1, 0, 0, 0);
      step("e_b2", 1, 0, 0, 0, 0);
      step("e_b3", 1, 0, 0, 0, 0);
      step("e_b4", 1, 1, 0, 0, 1);
      step("e_stay", 1, 1, 0, 0, 1);
      step("e_exit", 0, 0, 0, 0, 0);
      step("e_g1", 1, 1, 0, 0, 0);
      step("e_g2", 1, 0, 0, 0, 0);
      step("e_g3", 1, 1, 0, 0, 0);
      step("e_g4", 1, 0, 0, 0, 0);
      step("e_gmode", 1, 1, 1, 1, 0);

      // Abort in the key phase, then a full good sequence.
      do_reset("rst3");
      step("a_b1", 1, 1, 0, 0, 0);
      step("a_b2", 1, 0, 0, 0, 0);
      step("a_gap", 0, 0, 0, 0, 0);
      step("a_g1", 1, 1, 0, 0, 0);
      step("a_g2", 1, 0, 0, 0, 0);
      step("a_g3", 1, 1, 0, 0, 0);
      step("a_g4", 1, 0, 0, 0, 0);
      step("a_gmode", 1, 1, 1, 1, 0);

      // Abort while waiting for the mode bit; partial key must be discarded.
      do_reset("rst4");
      step("m_b1", 1, 1, 0, 0, 0);
      step("m_b2", 1, 0, 0, 0, 0);
      step("m_b3", 1, 1, 0, 0, 0);
      step("m_b4", 1, 0, 0, 0, 0);
      step("m_gap", 0, 1, 0, 0, 0);
      step("m_late", 1, 1, 0, 0, 0);
      step("m_idle", 0, 0, 0, 0, 0);

      // Reset mid-sequence discards progress.
      step("r_b1", 1, 1, 0, 0, 0);
      step("r_b2", 1, 0, 0, 0, 0);
      step("r_b3", 1, 1, 0, 0, 0);
      do_reset("rst5");
      step("r_g1", 1, 1, 0, 0, 0);
      step("r_g2", 1, 0, 0, 0, 0);
      step("r_g3", 1, 1, 0, 0, 0);
      step("r_g4", 1, 0, 0, 0, 0);
      step("r_gmode", 1, 1, 1, 1, 0);

      // In ACTIVE: inputs are ignored.
      for (int i = 0; i < 10; i++)
         step("act_ign", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, 1, 0);

      // Reset between edges clears outputs before the next edge.
      #2 reset = 1'b0;
      #1;
      exp_q.push_back(3'b000);
      check_now("async_rst");
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      step("post_rst", 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dec_input_key.md
DEC_INPUT_KEY -- requirements
Module: dec_input_key

Interface
REQ-001 Parameter: KEY_WIDTH, default 4, number of serial key bits preceding the mode bit (legal values 1..16).
REQ-002 Parameter: KEY_VALUE, default 4'b1010, expected key, first-received bit is MSB.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: inputKey  input  1  serial key/mode data bit, sampled on rising clk when validCmd=1.
REQ-006 Port: validCmd  input  1  qualifies inputKey; one bit consumed per rising clk while high.
REQ-007 Port: active  output  1  registered; 1 = correct key received and mode captured.
REQ-008 Port: mode  output  1  registered; captured mode bit, valid only while active=1, else 0.

Function
REQ-009 States: IDLE, KEY, MODE, ACTIVE, ERROR; internal bit counter (clog2(KEY_WIDTH+1) bits) and KEY_WIDTH-bit shift register.
REQ-010 IDLE: on rising clk with validCmd=1, shift inputKey into key register, counter=1, go to KEY (or MODE if KEY_WIDTH=1).
REQ-011 KEY: each rising clk with validCmd=1 shifts inputKey in (left shift, new bit LSB), counter increments; after KEY_WIDTH bits total, go to MODE.
REQ-012 Key comparison occurs when the last key bit is shifted in: match -> MODE; mismatch -> ERROR.
REQ-013 MODE: rising clk with validCmd=1 latches inputKey into mode and sets active=1 on that same edge; go to ACTIVE.
REQ-014 Latency: active rises at the edge sampling the mode bit, i.e. KEY_WIDTH+1 valid clocks after first valid bit.
REQ-015 ACTIVE: active=1 and mode held constant; validCmd and inputKey ignored; exit only via reset.
REQ-016 ERROR: active=0, mode=0; remain while validCmd=1; on clock with validCmd=0 return to IDLE, clear counter and key register.
REQ-017 validCmd=0 in KEY or MODE: abort to IDLE on that edge, discard partial key, outputs stay 0.
REQ-018 validCmd=0 in IDLE: no state change.
REQ-019 active=0 and mode=0 in every state except ACTIVE.

Reset
REQ-020 reset=0 asynchronously forces IDLE, counter=0, key register=0, active=0, mode=0 (and keyErr=0 when present).
REQ-021 reset asserted mid-sequence or in ACTIVE discards all progress; first valid bit after release starts a new key.
REQ-022 Reset release is synchronized internally (two-flop deassertion synchronizer); assertion remains asynchronous.

Configuration
REQ-023 Macro DEC_INPUT_KEY_ERR_FLAG_EN defined: extra output port keyErr (output, 1 bit, registered) is 1 while in ERROR, 0 otherwise.
REQ-024 Macro DEC_INPUT_KEY_ERR_FLAG_EN undefined: no keyErr port; all other behaviour identical.

Verification
REQ-025 Reset low, release, validCmd=1, bits 1,0,1,0,1 on 5 edges -> active=1, mode=1 from 5th edge; stay after validCmd=0.
REQ-026 After reset pulse, bits 1,0,1,0,0 -> active=1, mode=0 from 5th edge.
REQ-027 After reset, bits 1,0,0,1 -> ERROR, active=0, mode=0 (keyErr=1 with macro); validCmd=0 -> IDLE, keyErr=0.
REQ-028 Bits 1,0 then validCmd=0 for one edge, then 1,0,1,0,1 -> abort then active=1, mode=1 on 5th bit of second sequence.
REQ-029 In ACTIVE with mode=1, toggle inputKey/validCmd 10 cycles -> outputs unchanged; reset=0 mid-cycle -> active=0, mode=0 immediately, before next edge.
